// File: rtl/ksa_pipe.sv
// rtl/ksa_pipe.sv - pipelined Kogge-Stone adder with valid/ready handshake
// Optional signed-overflow output ovf is built when KSA_PIPE_OVF_EN is defined.
module ksa_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
`ifdef KSA_PIPE_OVF_EN
    output logic             c_out,
    output logic             ovf
`else
    output logic             c_out
`endif
);
    localparam int LEVELS = $clog2(WIDTH);
    localparam int PER    = (LEVELS + STAGES) / STAGES;
    localparam int IDX_W  = (LEVELS > 0) ? LEVELS : 1;

    // Ops (prefix levels 0..LEVELS-1, then the sum XOR) are packed toward the
    // output so the XOR always lands in the last stage.
    function automatic int op_stage(input int op);
        return STAGES - 1 - (LEVELS - op) / PER;
    endfunction

    function automatic void prefix_level(
        input  int               lvl,
        input  logic [WIDTH-1:0] g_in,
        input  logic [WIDTH-1:0] p_in,
        output logic [WIDTH-1:0] g_out,
        output logic [WIDTH-1:0] p_out
    );
        logic [IDX_W-1:0] idx;
        g_out = g_in;
        p_out = p_in;
        for (int i = 0; i < WIDTH; i++) begin
            if (i >= (1 << lvl)) begin
                idx      = IDX_W'(i - (1 << lvl));
                g_out[i] = g_in[i] | (p_in[i] & g_in[idx]);
                p_out[i] = p_in[i] & p_in[idx];
            end
        end
    endfunction

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] v_in;
    logic [STAGES-1:0] take;
    logic [STAGES-1:0] load;
    logic              full;

    always_comb begin
        v_in    = '0;
        v_in[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            v_in[k] = v[k-1];
        end
    end

    // A stage can take new content when it, or any stage after it, is empty,
    // or when the output is being consumed this cycle.
    always_comb begin
        take = '0;
        full = 1'b1;
        for (int k = STAGES - 1; k >= 0; k--) begin
            full    = full & v[k];
            take[k] = out_ready || !full;
        end
    end

    assign load      = take & v_in;
    assign in_ready  = take[0] && !rst;
    assign out_valid = v[STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (take[k]) begin
                    v[k] <= v_in[k];
                end
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] g_i;
        logic [WIDTH-1:0] p_i;
        logic [WIDTH-1:0] h_i;
        logic             c_i;

        if (k == 0) begin : g_src
            // Carry-in is folded into bit 0 generate so the prefix yields true carries.
            always_comb begin
                h_i    = a ^ b;
                p_i    = a ^ b;
                g_i    = a & b;
                g_i[0] = (a[0] & b[0]) | ((a[0] ^ b[0]) & c_in);
                c_i    = c_in;
            end
        end else begin : g_reg
            always_ff @(posedge clk) begin
                if (load[k-1]) begin
                    g_i <= g_stage[k-1].g_mid.g_o;
                    p_i <= g_stage[k-1].g_mid.p_o;
                    h_i <= g_stage[k-1].h_i;
                    c_i <= g_stage[k-1].c_i;
                end
            end
        end

        if (k < STAGES - 1) begin : g_mid
            logic [WIDTH-1:0] g_o;
            logic [WIDTH-1:0] p_o;
            logic [WIDTH-1:0] g_n;
            logic [WIDTH-1:0] p_n;

            always_comb begin
                g_n = '0;
                p_n = '0;
                g_o = g_i;
                p_o = p_i;
                for (int j = 0; j < LEVELS; j++) begin
                    if (op_stage(j) == k) begin
                        prefix_level(j, g_o, p_o, g_n, p_n);
                        g_o = g_n;
                        p_o = p_n;
                    end
                end
            end
        end else begin : g_last
            logic [WIDTH-1:0] g_f;
            logic [WIDTH-1:0] p_f;
            logic [WIDTH-1:0] g_n;
            logic [WIDTH-1:0] p_n;
            logic [WIDTH-1:0] s_n;
            logic             c_n;

            always_comb begin
                g_n = '0;
                p_n = '0;
                g_f = g_i;
                p_f = p_i;
                for (int j = 0; j < LEVELS; j++) begin
                    if (op_stage(j) == k) begin
                        prefix_level(j, g_f, p_f, g_n, p_n);
                        g_f = g_n;
                        p_f = p_n;
                    end
                end
                s_n = h_i ^ {g_f[WIDTH-2:0], c_i};
                c_n = g_f[WIDTH-1];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    s     <= '0;
                    c_out <= 1'b0;
                end else if (load[k]) begin
                    s     <= s_n;
                    c_out <= c_n;
                end
            end

`ifdef KSA_PIPE_OVF_EN
            // Signed overflow equals carry into the MSB differing from carry out.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf <= 1'b0;
                end else if (load[k]) begin
                    ovf <= g_f[WIDTH-1] ^ g_f[WIDTH-2];
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_ksa_pipe.sv
// tb/tb_ksa_pipe.sv - self-checking bench for ksa_pipe
// Directed cases on an 8-bit/2-stage instance plus random streams on several configurations.
module tb_ksa_pipe;

`ifdef KSA_PIPE_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif
    localparam int NBEATS = 1000;
    localparam int NCFG   = 4;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       c_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] s;
    logic       c_out;
    logic       ovf;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ksa_pipe #(.WIDTH(8), .STAGES(2)) u_dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .c_in(c_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .s(s),
`ifdef KSA_PIPE_OVF_EN
        .c_out(c_out),
        .ovf(ovf)
`else
        .c_out(c_out)
`endif
    );
`ifndef KSA_PIPE_OVF_EN
    assign ovf = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] exp8(input logic [7:0] x, input logic [7:0] y, input logic ci);
        logic [8:0] sum;
        logic       v;
        sum = {1'b0, x} + {1'b0, y} + {8'd0, ci};
        v   = OVF_ON && (x[7] == y[7]) && (sum[7] != x[7]);
        return {v, sum};
    endfunction

    task automatic single(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input string tag);
        int lat;
        @(negedge clk);
        a = ta; b = tb; c_in = tc; in_valid = 1'b1; out_ready = 1'b1;
        #1 check({tag, "_in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0; a = ~ta; b = ~tb;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, 2);
        check({tag, "_sum"}, {ovf, c_out, s}, exp8(ta, tb, tc));
    endtask

    for (genvar ci = 0; ci < NCFG; ci++) begin : g_rand
        localparam int W = (ci < 2) ? 8 : 32;
        localparam int S = (ci == 0) ? 1 : (ci == 1) ? 4 : (ci == 2) ? 1 : 6;

        logic         r_rst, r_iv, r_ir, r_cin, r_ov, r_or, r_co, r_ovf;
        logic [W-1:0] r_a, r_b, r_s;

        ksa_pipe #(.WIDTH(W), .STAGES(S)) u_rand (
            .clk(clk),
            .rst(r_rst),
            .in_valid(r_iv),
            .in_ready(r_ir),
            .a(r_a),
            .b(r_b),
            .c_in(r_cin),
            .out_valid(r_ov),
            .out_ready(r_or),
            .s(r_s),
`ifdef KSA_PIPE_OVF_EN
            .c_out(r_co),
            .ovf(r_ovf)
`else
            .c_out(r_co)
`endif
        );
`ifndef KSA_PIPE_OVF_EN
        assign r_ovf = 1'b0;
`endif

        initial begin
            logic [W+1:0] q[$];
            logic [W:0]   sum;
            logic         vo;
            int           sent;
            int           got;
            int           cyc;
            string        tag;
            tag  = $sformatf("rand_w%0d_s%0d", W, S);
            sent = 0; got = 0; cyc = 0;
            r_rst = 1'b1; r_iv = 1'b0; r_a = '0; r_b = '0; r_cin = 1'b0; r_or = 1'b0;
            repeat (3) @(negedge clk);
            r_rst = 1'b0;
            while (got < NBEATS && cyc < 20000) begin
                @(negedge clk);
                cyc++;
                r_iv  = (sent < NBEATS) && ($urandom_range(0, 3) != 0);
                r_a   = W'($urandom);
                r_b   = W'($urandom);
                if ($urandom_range(0, 7) == 0) r_a = '1;
                if ($urandom_range(0, 7) == 0) r_b = '1;
                r_cin = 1'($urandom);
                r_or  = ($urandom_range(0, 2) != 0);
                #1;
                if (r_ov && r_or) begin
                    if (q.size() == 0) begin
                        check({tag, "_spurious"}, 1, 0);
                    end else begin
                        check(tag, {r_ovf, r_co, r_s}, q.pop_front());
                    end
                    got++;
                end
                if (r_iv && r_ir) begin
                    sum = {1'b0, r_a} + {1'b0, r_b} + {{W{1'b0}}, r_cin};
                    vo  = OVF_ON && (r_a[W-1] == r_b[W-1]) && (sum[W-1] != r_a[W-1]);
                    q.push_back({vo, sum});
                    sent++;
                end
            end
            check({tag, "_count"}, got, NBEATS);
            check({tag, "_leftover"}, q.size(), 0);
            done_cnt++;
        end
    end

    initial begin
        logic [9:0] q[$];
        logic [9:0] held;
        logic       stall_prev;
        int         sent;
        int         got;
        int         cyc;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", {ovf, c_out, s}, 0);
        check("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        #1 check("post_rst_in_ready", in_ready, 1);

        single(8'hAA, 8'h24, 1'b0, "aa_24");
        single(8'hFF, 8'h01, 1'b1, "ff_01_c");
        single(8'h00, 8'h00, 1'b1, "00_00_c");
        single(8'h7F, 8'h01, 1'b0, "7f_01");
        single(8'h80, 8'hFF, 1'b0, "80_ff");

        sent = 0; got = 0; cyc = 0; stall_prev = 1'b0; held = '0;
        while (got < 10 && cyc < 60) begin
            @(negedge clk);
            in_valid  = (sent < 10);
            a         = 8'($urandom);
            b         = 8'($urandom);
            c_in      = 1'($urandom);
            out_ready = !(cyc >= 3 && cyc <= 6);
            #1;
            if (stall_prev) check("bb_stall_hold", {ovf, c_out, s}, held);
            check("bb_in_ready", in_ready, out_ready || (q.size() < 2));
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("bb_spurious", 1, 0);
                else check("bb_result", {ovf, c_out, s}, q.pop_front());
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back(exp8(a, b, c_in));
                sent++;
            end
            stall_prev = out_valid && !out_ready;
            held       = {ovf, c_out, s};
            cyc++;
        end
        check("bb_count", got, 10);
        @(negedge clk);
        in_valid = 1'b0;

        @(negedge clk);
        in_valid = 1'b1; a = 8'h11; b = 8'h22; c_in = 1'b0; out_ready = 1'b0;
        #1 check("rm_in_ready0", in_ready, 1);
        @(negedge clk);
        a = 8'h33; b = 8'h44;
        #1 check("rm_in_ready1", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("rm_in_flight", out_valid, 1);
        rst = 1'b1;
        #1 check("rm_rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        check("rm_out_valid", out_valid, 0);
        check("rm_sum", {ovf, c_out, s}, 0);
        out_ready = 1'b1;
        #1 check("rm_post_in_ready", in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rm_no_stale", out_valid, 0);
        end

        for (int i = 0; i < 40000 && done_cnt < NCFG; i++) @(negedge clk);
        check("rand_done", done_cnt, NCFG);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
